// File: rtl/sbus_mem_slave_if.sv
// sbus request/response bundle shared by the CPU bus masters and memory responders.
// Handshake: a request is live while en=1 and completes in the first cycle with en=1 and stall=0.
interface sbus;
    logic        en;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data_w;
    logic [31:0] data_r;
    logic        stall;

    modport master (output en, we, size, addr, data_w, input data_r, stall);
    modport slave  (input en, we, size, addr, data_w, output data_r, stall);
endinterface

// File: rtl/sbus_mem_slave.sv
// Word-organised RAM behind an sbus slave port with programmable wait states,
// byte-enabled writes, registered read data and access-fault reporting.
module sbus_mem_slave #(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [31:0] BASE      = 32'h0000_0000,
    parameter int unsigned LATENCY   = 0,
    parameter string       INIT_FILE = ""
) (
    input  logic clk,
    input  logic rst,
    sbus.slave   bus,
    output logic err,
    output logic o_dbg_state
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [32:0] SPAN     = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_data_r;
    logic [31:0]   r_mem [DEPTH];

    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_fault;
    logic [3:0]    w_be;
    logic          w_done_ok;
    logic          w_complete;

    // Memory contents start at zero.
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) r_mem[i] = '0;
    end

    assign w_off = bus.addr - BASE;
    assign w_idx = w_off[AW+1:2];

    always_comb begin
        w_fault = 1'b0;
        w_be    = 4'b0000;
        if ({1'b0, w_off} >= SPAN) w_fault = 1'b1;
        case (bus.size)
            2'b00: w_be = 4'b0001 << bus.addr[1:0];
            2'b01: begin
                w_be = 4'b0011 << bus.addr[1:0];
                if (bus.addr[0]) w_fault = 1'b1;
            end
            2'b10: begin
                w_be = 4'b1111;
                if (bus.addr[1:0] != 2'b00) w_fault = 1'b1;
            end
            default: w_fault = 1'b1;
        endcase
    end

    // With zero wait states the first en cycle is already the completion cycle.
    assign w_done_ok  = ((r_state == S_IDLE) && (LATENCY == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd0));
    assign w_complete = bus.en && w_done_ok;
    assign bus.stall  = bus.en && !w_done_ok;
    assign err        = w_complete && w_fault;

    assign bus.data_r  = r_data_r;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_data_r <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.en && (LATENCY != 0)) begin
                        r_state <= S_WAIT;
                        r_cnt   <= CNT_INIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.en || (r_cnt == 4'd0)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
            if (w_complete && !w_fault && !bus.we) r_data_r <= r_mem[w_idx];
        end
    end

    // Memory has no reset; rst only blocks a write that coincides with it.
    always_ff @(posedge clk) begin
        if (!rst && w_complete && !w_fault && bus.we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= bus.data_w[8*i +: 8];
            end
        end
    end
endmodule
